// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register map,
// CTRL field positions, mode encodings and FSM state encodings.
package timer_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_W        = 4;

  // Modes 2 and 3 are treated as one-shot: only the reload code is tested for.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter timer behind the system bridge; IRQ feeds a CP0
// hardware interrupt line. One-shot mode holds the flag, reload mode pulses it.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             IRQ
);

  logic [CTRL_W-1:0] ctrl;
  logic [WIDTH-1:0]  preset;
  logic [WIDTH-1:0]  count;
  state_t            state;
  logic              irq_flag;

  logic wr_ctrl, wr_preset, en, reload;
  logic unused_addr;

  assign unused_addr = ^{Addr[31:4], Addr[1:0]};
  assign wr_ctrl     = WE && (Addr[3:2] == REG_CTRL);
  assign wr_preset   = WE && (Addr[3:2] == REG_PRESET);
  assign en          = ctrl[CTRL_EN];
  assign reload      = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl                              <= '0;
      ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] <= MODE_ONESHOT;
      preset                            <= '0;
      count                             <= '0;
      state                             <= ST_IDLE;
      irq_flag                          <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= en ? ST_CNT : ST_IDLE;
        end
        ST_CNT: begin
          if (!en)                 state <= ST_IDLE;
          else if (count == '0)    state <= ST_INT;
          else                     count <= count - WIDTH'(1);
        end
        ST_INT: begin
          if (reload) begin
            state <= ST_LOAD;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= ST_IDLE;
          end
        end
      endcase

      // Setting from INT beats any clear on the same edge; reload mode clears
      // on every other edge so the flag is a single-cycle pulse.
      if (state == ST_INT)                      irq_flag <= 1'b1;
      else if (wr_ctrl || wr_preset || reload)  irq_flag <= 1'b0;

      // Software CTRL write lands after the INT enable clear and so wins.
      if (wr_ctrl)   ctrl   <= Din[CTRL_W-1:0];
      if (wr_preset) preset <= Din;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      REG_CTRL:   Dout[CTRL_W-1:0] = ctrl;
      REG_PRESET: Dout = preset;
      REG_COUNT:  Dout = count;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus random register traffic,
// all checked against an elapsed-time reference model of the timer.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  timer_counter #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #10 clk = ~clk;

  // Reference model: a running timer is described by edges elapsed since the
  // start of its period (m_t) and the preset latched for that period (m_pl).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_hold;
  bit          m_flag;
  bit          m_run;
  longint      m_t;
  longint      m_pl;

  function automatic logic [31:0] m_count();
    longint dec;
    if (m_run && m_t >= 1) begin
      dec = (m_t - 1 < m_pl) ? m_t - 1 : m_pl;
      return 32'(m_pl - dec);
    end
    return m_hold;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_hold = '0;
    m_flag = 0; m_run = 0; m_t = 0; m_pl = 0;
  endtask

  task automatic model_edge(input bit we, input logic [1:0] a, input logic [31:0] d);
    bit          en, rl, fire;
    logic [31:0] cur;
    en   = m_ctrl[0];
    rl   = (m_ctrl[2:1] == 2'd1);
    fire = 0;
    cur  = m_count();
    if (!m_run) begin
      if (en) begin m_run = 1; m_t = 0; end
    end else if (m_t == 0) begin
      m_pl   = longint'(m_preset);
      m_hold = m_preset;
      if (en) m_t = 1; else m_run = 0;
    end else if (m_t <= m_pl + 1) begin
      if (!en) begin m_run = 0; m_hold = cur; end
      else m_t++;
    end else begin
      fire   = 1;
      m_hold = 0;
      if (rl) m_t = 0;
      else begin m_run = 0; m_ctrl[0] = 1'b0; end
    end
    if (fire) m_flag = 1;
    else if ((we && (a == 2'd0 || a == 2'd1)) || rl) m_flag = 0;
    if (we && a == 2'd0) m_ctrl = d[3:0];
    if (we && a == 2'd1) m_preset = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp [4];
    exp[0] = {28'h0, m_ctrl};
    exp[1] = m_preset;
    exp[2] = m_count();
    exp[3] = '0;
    chk($sformatf("%s_irq", tag), 32'(IRQ), 32'(m_flag & m_ctrl[3]));
    for (int a = 0; a < 4; a++) begin
      Addr = 32'(a << 2);
      #1;
      chk($sformatf("%s_r%0d", tag, a), Dout, exp[a]);
    end
  endtask

  // One clock: drive a bus cycle, step the model on the edge, check all state.
  task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] d);
    WE = we; Addr = {28'h0, a, 2'b00}; Din = d;
    @(posedge clk);
    model_edge(we, a, d);
    #1;
    WE = 1'b0;
    check_all("cyc");
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'h0, a, 2'b00};
    #1;
    v = Dout;
  endtask

  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          first, hi;
    bit          found, rwe;
    logic [1:0]  ra;
    logic [31:0] rdat;
    int          q[$];

    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    model_reset();
    #15;
    check_all("por");
    reset = 1'b0;

    // One-shot, PRESET=3
    cyc(1, 2'd1, 32'd3);
    cyc(1, 2'd0, 32'h9);
    first = -1;
    for (int k = 1; k <= 30 && first < 0; k++) begin
      cyc(0, 2'd0, '0);
      if (k == 2) begin rd(2'd2, v); chk("t2_load", v, 32'd3); end
      if (IRQ === 1'b1) first = k;
    end
    chk("t2_irq_lat", 32'(first), 32'd7);
    rd(2'd0, v); chk("t2_ctrl", v, 32'h8);
    hi = 0;
    for (int k = 0; k < 20; k++) begin cyc(0, 2'd0, '0); if (IRQ === 1'b1) hi++; end
    chk("t2_hold", 32'(hi), 32'd20);
    cyc(1, 2'd0, 32'h0);
    chk("t2_drop", 32'(IRQ), 32'd0);

    // Auto-reload, PRESET=2: pulses at 6, 11, 16, 21
    cyc(1, 2'd1, 32'd2);
    cyc(1, 2'd0, 32'hB);
    q.delete();
    for (int k = 1; k <= 24; k++) begin cyc(0, 2'd0, '0); if (IRQ === 1'b1) q.push_back(k); end
    chk("t3_npulse", 32'(q.size()), 32'd4);
    for (int i = 0; i < q.size(); i++) chk($sformatf("t3_pulse%0d", i), 32'(q[i]), 32'(6 + 5 * i));
    rd(2'd0, v); chk("t3_ctrl", v, 32'hB);
    cyc(1, 2'd0, 32'h0);

    // Disable mid-count, then re-enable
    cyc(1, 2'd1, 32'd10);
    cyc(1, 2'd0, 32'h9);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      cyc(0, 2'd0, '0);
      rd(2'd2, v);
      if (v == 32'd7) found = 1;
    end
    chk("t4_find", 32'(found), 32'd1);
    cyc(1, 2'd0, 32'h8);
    for (int k = 0; k < 5; k++) cyc(0, 2'd0, '0);
    rd(2'd2, v); chk("t4_frozen", v, 32'd6);
    chk("t4_noirq", 32'(IRQ), 32'd0);
    cyc(1, 2'd0, 32'h9);
    cyc(0, 2'd0, '0);
    cyc(0, 2'd0, '0);
    rd(2'd2, v); chk("t4_reload", v, 32'd10);
    cyc(1, 2'd0, 32'h0);

    // Masked zero preset, then IM set by a write that also clears the flag
    cyc(1, 2'd1, 32'd0);
    cyc(1, 2'd0, 32'h1);
    hi = 0;
    for (int k = 0; k < 8; k++) begin cyc(0, 2'd0, '0); if (IRQ === 1'b1) hi++; end
    chk("t5_masked", 32'(hi), 32'd0);
    cyc(1, 2'd0, 32'h8);
    hi = 0;
    for (int k = 0; k < 4; k++) begin cyc(0, 2'd0, '0); if (IRQ === 1'b1) hi++; end
    chk("t5_cleared", 32'(hi), 32'd0);

    // Preset change during CNT in reload mode; COUNT writes ignored
    cyc(1, 2'd1, 32'd5);
    cyc(1, 2'd0, 32'hB);
    q.delete();
    for (int k = 1; k <= 20; k++) begin
      case (k)
        3:       cyc(1, 2'd1, 32'd1);
        4:       cyc(1, 2'd2, 32'hFFFF);
        default: cyc(0, 2'd0, '0);
      endcase
      if (k == 5) begin rd(2'd2, v); chk("t6_cnt", v, 32'd2); end
      if (IRQ === 1'b1) q.push_back(k);
    end
    chk("t6_npulse", 32'(q.size()), 32'd3);
    for (int i = 0; i < q.size(); i++) chk($sformatf("t6_pulse%0d", i), 32'(q[i]), 32'(9 + 4 * i));
    cyc(1, 2'd0, 32'h0);

    // Asynchronous reset mid-count, then with a held interrupt
    cyc(1, 2'd1, 32'd20);
    cyc(1, 2'd0, 32'hF);
    for (int k = 0; k < 5; k++) cyc(0, 2'd0, '0);
    async_reset();
    cyc(1, 2'd1, 32'd0);
    cyc(1, 2'd0, 32'hF);
    for (int k = 0; k < 6; k++) cyc(0, 2'd0, '0);
    chk("t1_pre_irq", 32'(IRQ), 32'd1);
    async_reset();

    // Random register traffic
    for (int i = 0; i < 400; i++) begin
      rwe  = ($urandom_range(0, 5) == 0);
      ra   = 2'($urandom_range(0, 3));
      rdat = (ra == 2'd1) ? 32'($urandom_range(0, 12)) : 32'($urandom);
      cyc(rwe, ra, rdat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
